// File: rtl/rgmii_pll_ctrl.sv
// RGMII PLL lock/reset sequencer with runtime ODIV0 reconfiguration.
// Optional RUN-state lock monitor: define PLL_CTRL_LOCK_MON_EN.
module rgmii_pll_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned RETRY_MAX     = 3,
  parameter logic [6:0]  DIV_DEFAULT   = 7'd7
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       enclk0,
  output logic [6:0] odsel0,
  input  logic       cfg_valid,
  input  logic [6:0] cfg_div,
  output logic       cfg_ready,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       clk_ready,
  output logic       pll_fail,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CW =
    $clog2(LOCK_TIMEOUT + RST_CYCLES + STABLE_CYCLES + GATE_CYCLES + 1);
  localparam int unsigned RW = $clog2(RETRY_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [RW-1:0] R_LAST    = RW'(RETRY_MAX - 1);
  localparam logic [RW-1:0] R_ONE     = RW'(1);

  typedef enum logic [2:0] {
    RST_HOLD, WAIT_LOCK, STABLE, RUN, GATE, FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [6:0]    div_q, div_d;
  logic [6:0]    odsel_q, odsel_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          prst_q, run_q, rdy_q, fail_q;
  logic          lock_s1_q, lock_s_q;
  logic          accept, lock_lost;

`ifdef PLL_CTRL_LOCK_MON_EN
  logic [7:0]    llc_q, llc_d;
  assign lock_lost     = ~lock_s_q;
  assign lock_loss_cnt = llc_q;
`else
  assign lock_lost     = 1'b0;
  assign lock_loss_cnt = 8'd0;
`endif

  assign accept = cfg_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + C_ONE;
    retry_d = retry_q;
    div_d   = div_q;
    odsel_d = odsel_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PLL_CTRL_LOCK_MON_EN
    llc_d   = llc_q;
`endif
    unique case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_q + R_ONE;
          state_d = (retry_q == R_LAST) ? FAULT : RST_HOLD;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        // lock loss takes priority over a concurrent request
        if (lock_lost) begin
          state_d = RST_HOLD;
          retry_d = '0;
`ifdef PLL_CTRL_LOCK_MON_EN
          if (llc_q != 8'hff) llc_d = llc_q + 8'd1;
`endif
        end else if (accept) begin
          if (cfg_div == 7'd0) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            div_d   = cfg_div;
            state_d = GATE;
          end
        end
      end
      GATE: begin
        if (cnt_q == GATE_LAST) begin
          odsel_d = div_q;
          pend_d  = 1'b1;
          state_d = RST_HOLD;
        end
      end
      FAULT: begin
        cnt_d = '0;
        if (accept) begin
          if (cfg_div == 7'd0) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            div_d   = cfg_div;
            odsel_d = cfg_div;
            pend_d  = 1'b1;
            retry_d = '0;
            state_d = RST_HOLD;
          end
        end
      end
      default: state_d = RST_HOLD;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (pend_q && state_d != state_q) begin
      if (state_d == RUN) begin
        done_d = 1'b1;
        pend_d = 1'b0;
      end else if (state_d == FAULT) begin
        done_d = 1'b1;
        err_d  = 1'b1;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= RST_HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      div_q     <= DIV_DEFAULT;
      odsel_q   <= DIV_DEFAULT;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      prst_q    <= 1'b1;
      run_q     <= 1'b0;
      rdy_q     <= 1'b0;
      fail_q    <= 1'b0;
      lock_s1_q <= 1'b0;
      lock_s_q  <= 1'b0;
`ifdef PLL_CTRL_LOCK_MON_EN
      llc_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      div_q     <= div_d;
      odsel_q   <= odsel_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      err_q     <= err_d;
      prst_q    <= (state_d == RST_HOLD) || (state_d == FAULT);
      run_q     <= (state_d == RUN);
      rdy_q     <= (state_d == RUN) || (state_d == FAULT);
      fail_q    <= (state_d == FAULT);
      lock_s1_q <= pll_lock;
      lock_s_q  <= lock_s1_q;
`ifdef PLL_CTRL_LOCK_MON_EN
      llc_q     <= llc_d;
`endif
    end
  end

  assign pll_reset = prst_q;
  assign enclk0    = run_q;
  assign clk_ready = run_q;
  assign odsel0    = odsel_q;
  assign cfg_ready = rdy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign pll_fail  = fail_q;

endmodule

// File: tb/tb_rgmii_pll_ctrl.sv
// Directed bench for rgmii_pll_ctrl with a simple PLL lock model
// (lock 100 cycles after PLL reset is released).
module tb_rgmii_pll_ctrl;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock;
  logic       pll_reset;
  logic       enclk0;
  logic [6:0] odsel0;
  logic       cfg_valid = 1'b0;
  logic [6:0] cfg_div = 7'd0;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_err;
  logic       clk_ready;
  logic       pll_fail;
  logic [7:0] lock_loss_cnt;

  logic force_low = 1'b0;
  logic lock_en = 1'b1;
  int   lcnt = 0;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  rgmii_pll_ctrl dut (
    .clkin(clkin),
    .rst(rst),
    .pll_lock(pll_lock),
    .pll_reset(pll_reset),
    .enclk0(enclk0),
    .odsel0(odsel0),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err),
    .clk_ready(clk_ready),
    .pll_fail(pll_fail),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #4 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  always @(posedge clkin) begin
    if (pll_reset) lcnt <= 0;
    else if (lcnt != 100) lcnt <= lcnt + 1;
  end

  assign pll_lock = (lcnt == 100) && lock_en && !force_low;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sigv(input int sel);
    case (sel)
      0: return clk_ready;
      1: return cfg_done;
      2: return pll_lock;
      3: return pll_reset;
      4: return pll_fail;
      5: return enclk0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic val,
                            input int maxc, output int n);
    n = 0;
    while (sigv(sel) !== val && n < maxc) begin
      @(negedge clkin);
      n++;
    end
  endtask

  task automatic request(input logic [6:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    @(negedge clkin);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n, c0, cp, bad, falls, dn;
    logic prev;

    // reset values
    repeat (3) @(negedge clkin);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_enclk0", enclk0, 0);
    chk("rst_odsel0", odsel0, 7);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_clk_ready", clk_ready, 0);
    chk("rst_pll_fail", pll_fail, 0);
    chk("rst_llc", lock_loss_cnt, 0);

    // bring-up
    rst = 1'b0;
    wait_until(3, 1'b0, 100, n);
    chk("bring_rst_width", n, 16);
    wait_until(2, 1'b1, 200, n);
    wait_until(0, 1'b1, 200, n);
    chk("bring_lock_to_ready", n, 67);
    chk("bring_odsel0", odsel0, 7);
    chk("bring_enclk0", enclk0, 1);
    chk("bring_cfg_ready", cfg_ready, 1);

    // divider change to 28
    request(7'd28);
    c0 = cyc;
    chk("div28_enclk0_off", enclk0, 0);
    chk("div28_ready_off", clk_ready, 0);
    chk("div28_cfg_ready", cfg_ready, 0);
    n = 0;
    bad = 0;
    while (odsel0 == 7'd7 && n < 50) begin
      if (enclk0 !== 1'b0) bad++;
      n++;
      @(negedge clkin);
    end
    chk("div28_gate_len", n, 4);
    chk("div28_gate_enclk", bad, 0);
    chk("div28_odsel0", odsel0, 28);
    chk("div28_pll_reset", pll_reset, 1);
    wait_until(1, 1'b1, 400, n);
    chk("div28_latency", cyc - c0, 187);
    chk("div28_err", cfg_err, 0);
    chk("div28_enclk0_on", enclk0, 1);
    chk("div28_clk_ready", clk_ready, 1);
    @(negedge clkin);
    chk("div28_done_pulse", cfg_done, 0);

    // illegal divider
    request(7'd0);
    chk("div0_done", cfg_done, 1);
    chk("div0_err", cfg_err, 1);
    chk("div0_odsel0", odsel0, 28);
    chk("div0_enclk0", enclk0, 1);
    chk("div0_cfg_ready", cfg_ready, 1);
    @(negedge clkin);
    chk("div0_done_pulse", cfg_done, 0);
    chk("div0_err_clr", cfg_err, 0);

    // 1-cycle lock dropout during STABLE forces full requalification
    request(7'd10);
    wait_until(2, 1'b0, 50, n);
    wait_until(2, 1'b1, 300, n);
    repeat (20) @(negedge clkin);
    force_low = 1'b1;
    cp = cyc;
    @(negedge clkin);
    force_low = 1'b0;
    wait_until(0, 1'b1, 200, n);
    chk("stable_requal", cyc - cp, 68);
    chk("stable_done", cfg_done, 1);
    chk("stable_err", cfg_err, 0);
    chk("stable_odsel0", odsel0, 10);

    // lock loss in RUN
    @(negedge clkin);
    force_low = 1'b1;
`ifdef PLL_CTRL_LOCK_MON_EN
    wait_until(5, 1'b0, 10, n);
    chk("mon_enclk_fall", n, 3);
    chk("mon_clk_ready", clk_ready, 0);
    chk("mon_llc", lock_loss_cnt, 1);
    chk("mon_pll_reset", pll_reset, 1);
    repeat (7) @(negedge clkin);
    force_low = 1'b0;
    wait_until(0, 1'b1, 400, n);
    chk("mon_relock", clk_ready, 1);
    chk("mon_enclk0", enclk0, 1);
    chk("mon_no_done", cfg_done, 0);
    chk("mon_odsel0", odsel0, 10);
`else
    bad = 0;
    repeat (10) begin
      @(negedge clkin);
      if (enclk0 !== 1'b1 || clk_ready !== 1'b1) bad++;
    end
    force_low = 1'b0;
    chk("nomon_enclk_held", bad, 0);
    chk("nomon_llc", lock_loss_cnt, 0);
`endif

    // lock never comes: retries then FAULT
    @(negedge clkin);
    request(7'd20);
    lock_en = 1'b0;
    c0 = cyc;
    prev = pll_reset;
    falls = 0;
    n = 0;
    while (!pll_fail && n < 13000) begin
      @(negedge clkin);
      n++;
      if (prev && !pll_reset) falls++;
      prev = pll_reset;
    end
    chk("fault_pll_fail", pll_fail, 1);
    chk("fault_attempts", falls, 3);
    chk("fault_latency", cyc - c0, 12340);
    chk("fault_done", cfg_done, 1);
    chk("fault_err", cfg_err, 1);
    chk("fault_pll_reset", pll_reset, 1);
    chk("fault_cfg_ready", cfg_ready, 1);
    chk("fault_enclk0", enclk0, 0);
    chk("fault_odsel0", odsel0, 20);
    lock_en = 1'b1;
    @(negedge clkin);
    chk("fault_done_pulse", cfg_done, 0);
    request(7'd7);
    chk("recov_odsel0", odsel0, 7);
    chk("recov_pll_fail", pll_fail, 0);
    chk("recov_pll_reset", pll_reset, 1);
    chk("recov_cfg_ready", cfg_ready, 0);
    wait_until(1, 1'b1, 400, n);
    chk("recov_latency", n, 183);
    chk("recov_err", cfg_err, 0);
    chk("recov_clk_ready", clk_ready, 1);
    chk("recov_enclk0", enclk0, 1);

    // reset in the middle of a reconfiguration drops the request
    @(negedge clkin);
    request(7'd15);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_odsel0", odsel0, 7);
    chk("mid_rst_pll_reset", pll_reset, 1);
    chk("mid_rst_enclk0", enclk0, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    @(negedge clkin);
    rst = 1'b0;
    n = 0;
    dn = 0;
    while (!clk_ready && n < 400) begin
      @(negedge clkin);
      n++;
      if (cfg_done) dn++;
    end
    chk("mid_rst_relock", clk_ready, 1);
    chk("mid_rst_no_done", dn, 0);
    chk("mid_rst_odsel_end", odsel0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rgmii_pll_ctrl.md
# rgmii_pll_ctrl

Lock/reset sequencer and divider reconfiguration controller for the RGMII clock PLL. Runs on the free-running 125 MHz reference. Holds the PLL in reset, waits for qualified lock, and gates CLKOUT0 through ENCLK0 until the clock is stable. Serialises runtime ODIV0 change requests (link speed change) by gating the clock, loading the new divider, and relocking. The PLL is instantiated with DYN_ODIV0_SEL = "TRUE"; this block drives its RESET, ENCLK0 and ODSEL0 pins.

## Interface
Parameters:
- RST_CYCLES, 16: PLL reset pulse width, in clk cycles (≥2).
- LOCK_TIMEOUT, 4096: maximum cycles in WAIT_LOCK before a retry.
- STABLE_CYCLES, 64: consecutive synchronised-lock cycles required before the clock is released.
- GATE_CYCLES, 4: cycles with ENCLK0 low before the divider changes.
- RETRY_MAX, 3: lock attempts per sequence before FAULT.
- DIV_DEFAULT, 7: ODIV0 value after reset.

Ports:
- clkin  in  1  reference clock, 125 MHz; also feeds the PLL.
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  PLL LOCK. Asynchronous; synchronised internally with 2 flops.
- pll_reset  out  1  to PLL RESET.
- enclk0  out  1  to PLL ENCLK0.
- odsel0  out  7  to PLL ODSEL0; the divider value.
- cfg_valid  in  1  divider change request.
- cfg_div  in  7  requested ODIV0; 0 is illegal.
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
- cfg_done  out  1  1-cycle completion pulse.
- cfg_err  out  1  status, valid only with cfg_done.
- clk_ready  out  1  CLKOUT0 is locked and enabled.
- pll_fail  out  1  FAULT state indicator.
- lock_loss_cnt  out  8  saturating count of lock losses while in RUN.

## Operation
- States: RST_HOLD, WAIT_LOCK, STABLE, RUN, GATE, FAULT. Reset enters RST_HOLD with retry=0.
- RST_HOLD:
  - pll_reset=1, enclk0=0.
  - After RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset=0.
  - If lock_s (synchronised lock) is 1, go to STABLE.
  - If the timer reaches LOCK_TIMEOUT, increment retry. Go to FAULT if retry==RETRY_MAX; otherwise go to RST_HOLD.
- STABLE:
  - Counts consecutive cycles with lock_s=1.
  - If lock_s=0, go to WAIT_LOCK. The timeout timer restarts; retry is unchanged.
  - After STABLE_CYCLES consecutive cycles, go to RUN and clear retry.
- RUN:
  - enclk0=1, clk_ready=1, cfg_ready=1.
  - On cfg_valid with cfg_div≠0: latch cfg_div and go to GATE.
  - On cfg_valid with cfg_div==0: cfg_done=1 and cfg_err=1 in the next cycle; the state stays RUN.
- GATE:
  - enclk0=0, clk_ready=0.
  - After GATE_CYCLES cycles, odsel0 takes the latched divider and the state goes to RST_HOLD with the pending flag set.
- Pending completion:
  - Entering RUN with pending set gives cfg_done=1, cfg_err=0.
  - Entering FAULT with pending set gives cfg_done=1, cfg_err=1.
  - In both cases pending clears.
- FAULT:
  - pll_fail=1, pll_reset=1, cfg_ready=1.
  - An accepted legal request latches cfg_div, sets pending, clears retry, and goes to RST_HOLD. odsel0 is updated on that transition.
- cfg_valid is ignored in all states where cfg_ready=0.
- Simultaneous lock loss and cfg_valid in RUN: the lock loss wins. The request is not accepted (cfg_ready deasserts the next cycle).

## Timing
- Reset values: pll_reset=1, enclk0=0, odsel0=DIV_DEFAULT, cfg_ready=0, cfg_done=0, cfg_err=0, clk_ready=0, pll_fail=0, lock_loss_cnt=0.
- All outputs are registered.
- The lock path has 2 cycles of synchroniser latency before any state decision.
- enclk0 drops in the same cycle that clk_ready drops.
- odsel0 never changes while enclk0=1 or pll_reset=0.
- Minimum reconfiguration latency from acceptance to cfg_done: GATE_CYCLES + RST_CYCLES + 2 + STABLE_CYCLES + a few cycles of state overhead.
- Reset mid-operation: all state aborts immediately to reset values. Any pending request is dropped with no cfg_done.

## Configuration
- PLL_CTRL_LOCK_MON_EN defined:
  - In RUN, lock_s=0 forces enclk0=0 and clk_ready=0 and sends the state to RST_HOLD.
  - lock_loss_cnt increments and saturates at 255.
  - retry is cleared.
- Not defined:
  - RUN ignores lock_s.
  - lock_loss_cnt is tied to 0.
  - Lock is qualified only during WAIT_LOCK and STABLE.

## Test plan
- Release rst; the model asserts lock 100 cycles after pll_reset falls. Required: pll_reset high for 16 cycles, clk_ready=1 after lock+2+64 cycles, odsel0=7.
- In RUN, send cfg_valid with cfg_div=28. Required: enclk0 low for ≥4 cycles before odsel0=28, a PLL reset pulse, a relock, then one cfg_done with cfg_err=0 and enclk0=1.
- In RUN, send cfg_div=0. Required: cfg_done with cfg_err=1 one cycle later, and state, odsel0 and enclk0 unchanged.
- Lock never asserts. Required: 3 reset/timeout cycles (4096 cycles each), then pll_fail=1. A subsequent request with cfg_div=7 and lock restored must reach RUN and give cfg_done with cfg_err=0.
- With the macro defined, drop lock for 10 cycles in RUN. Required: enclk0 falls within 3 cycles, lock_loss_cnt=1, and automatic relock to RUN. Without the macro, enclk0 must stay 1.
- Pulse lock low for 1 cycle during STABLE. Required: return to WAIT_LOCK and a full 64-cycle requalification.
